// File: rtl/d_latch.sv
// Transparent-high D latch with asynchronous active-low clear.
// Q follows D while EN is high and holds the last value once EN falls.
module d_latch #(
    parameter int WIDTH = 1
) (
    output logic [WIDTH-1:0] Q,
    input  logic [WIDTH-1:0] D,
    input  logic             EN,
    input  logic             R
);

    logic [WIDTH-1:0] q_l;

    // Clear has priority over the gate; with EN low the previous value is kept.
    always_latch begin
        if (!R) begin
            q_l <= '0;
        end else if (EN) begin
            q_l <= D;
        end
    end

    assign Q = q_l;

endmodule

// File: tb/tb_d_latch.sv
// Directed bench for d_latch: a table of {R, EN, D, expected Q} steps plus
// short hand-written sequences for the edge-timing corners.
module tb_d_latch;

    localparam int W = 4;

    logic [W-1:0] q;
    logic [W-1:0] d;
    logic         en;
    logic         r;

    int checks = 0;
    int errors = 0;

    d_latch #(.WIDTH(W)) dut (
        .Q  (q),
        .D  (d),
        .EN (en),
        .R  (r)
    );

    typedef struct {
        logic         r;
        logic         en;
        logic [W-1:0] d;
        logic [W-1:0] exp_q;
        string        name;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic vr, input logic ven, input logic [W-1:0] vd,
                           input logic [W-1:0] vq, input string vn);
        vec_t v;
        v.r = vr;
        v.en = ven;
        v.d = vd;
        v.exp_q = vq;
        v.name = vn;
        vecs.push_back(v);
    endtask

    task automatic check(input logic [W-1:0] exp_q, input string name);
        checks++;
        if (q !== exp_q) begin
            errors++;
            $display("FAIL %s: Q=%h expected %h (t=%0t)", name, q, exp_q, $time);
        end
    endtask

    initial begin
        // Each step changes one input at a time, so D and EN never move together.
        add_vec(1'b0, 1'b1, 4'h0, 4'h0, "rst_dom_d0");
        add_vec(1'b0, 1'b1, 4'hF, 4'h0, "rst_dom_dF");
        add_vec(1'b0, 1'b1, 4'h0, 4'h0, "rst_dom_d0b");
        add_vec(1'b0, 1'b0, 4'h0, 4'h0, "rst_dom_en0");
        add_vec(1'b1, 1'b0, 4'h0, 4'h0, "release_hold");
        add_vec(1'b1, 1'b0, 4'hF, 4'h0, "release_hold_dF");
        add_vec(1'b1, 1'b0, 4'h0, 4'h0, "release_hold_d0");
        add_vec(1'b1, 1'b0, 4'hA, 4'h0, "lh_d_set_opaque");
        add_vec(1'b1, 1'b1, 4'hA, 4'hA, "lh_en_rise");
        add_vec(1'b1, 1'b0, 4'hA, 4'hA, "lh_en_fall");
        add_vec(1'b1, 1'b0, 4'h0, 4'hA, "lh_held");
        add_vec(1'b1, 1'b1, 4'h0, 4'h0, "ll_en_rise");
        add_vec(1'b1, 1'b0, 4'h0, 4'h0, "ll_en_fall");
        add_vec(1'b1, 1'b0, 4'h5, 4'h0, "ll_held");
        add_vec(1'b1, 1'b1, 4'h5, 4'h5, "tr_en_rise");
        add_vec(1'b1, 1'b1, 4'h0, 4'h0, "tr_d0");
        add_vec(1'b1, 1'b1, 4'h9, 4'h9, "tr_d9");
        add_vec(1'b1, 1'b1, 4'h6, 4'h6, "tr_d6");
        add_vec(1'b1, 1'b1, 4'hF, 4'hF, "tr_dF");
        add_vec(1'b1, 1'b0, 4'hF, 4'hF, "hold_F");
        add_vec(1'b0, 1'b0, 4'hF, 4'h0, "rst_mid_hold");
        add_vec(1'b1, 1'b0, 4'hF, 4'h0, "rst_rel_en0");
        add_vec(1'b1, 1'b1, 4'hF, 4'hF, "en_rise_after_rst");
        add_vec(1'b0, 1'b1, 4'hF, 4'h0, "rst_mid_transp");
        add_vec(1'b0, 1'b1, 4'h3, 4'h0, "rst_mid_transp_d3");
        add_vec(1'b1, 1'b1, 4'h3, 4'h3, "rst_rel_en1");

        r = 1'b0;
        en = 1'b0;
        d = '0;
        #5;
        check(4'h0, "power_up_reset");

        foreach (vecs[i]) begin
            #5;
            r = vecs[i].r;
            en = vecs[i].en;
            d = vecs[i].d;
            #5;
            check(vecs[i].exp_q, vecs[i].name);
        end

        // Transparent path has no latency: a D change shows up within 1 unit.
        d = 4'h7;
        #1;
        check(4'h7, "transp_immediate");

        // Capture uses the D present just before EN falls.
        d = 4'hC;
        #2;
        en = 1'b0;
        #1;
        d = 4'h3;
        #1;
        check(4'hC, "capture_before_fall");
        d = 4'h8;
        #3;
        check(4'hC, "hold_after_capture");

        // Clear acts immediately without any EN activity.
        r = 1'b0;
        #1;
        check(4'h0, "async_clear_immediate");
        r = 1'b1;
        #2;
        check(4'h0, "clear_retained_en0");

        // Reset release while transparent takes D immediately.
        en = 1'b1;
        #2;
        check(4'h8, "transp_after_release");
        r = 1'b0;
        #1;
        check(4'h0, "clear_in_transp");
        d = 4'h1;
        #1;
        check(4'h0, "clear_ignores_d");
        r = 1'b1;
        #1;
        check(4'h1, "release_takes_d");

        // Randomised transparent/hold pass with a one-value model.
        begin
            logic [W-1:0] model_q;
            model_q = 4'h1;
            for (int k = 0; k < 20; k++) begin
                #2;
                if (en) begin
                    en = 1'b0;
                end else begin
                    d = W'($urandom_range(0, 15));
                    #2;
                    en = 1'b1;
                    model_q = d;
                end
                #2;
                check(model_q, "rand_step");
                d = W'($urandom_range(0, 15));
                if (en) model_q = d;
                #2;
                check(model_q, "rand_d_change");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
